// File: rtl/mult_pkg.sv
// Shared types and default sizing for the multiply-block sequencer.
package mult_pkg;
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_FULL,
        ISSUE,
        READ,
        DONE
    } seq_state_t;

    localparam int DEF_LOGDEPTH = 6;
    localparam int DEF_DEPTH    = 2 ** DEF_LOGDEPTH;
endpackage

// File: rtl/mult_seq_timer.sv
// Idle-cycle watchdog: clears on clr, counts on en, flags the cycle whose
// increment would reach TIMEOUT.
module mult_seq_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && !clr && (cnt_q == TW'(TIMEOUT - 1));
endmodule

// File: rtl/mult_block_sequencer.sv
// Runs one load / wait-full / block-read transaction against the multiplier
// and forwards the product stream to the host with one cycle of latency.
module mult_block_sequencer
    import mult_pkg::*;
#(
    parameter int LOGDEPTH = DEF_LOGDEPTH,
    parameter int WIDTH    = 32,
    parameter int OPW      = 16,
    parameter int TIMEOUT  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [OPW-1:0]   op_a,
    input  logic [OPW-1:0]   op_b,
    output logic             EN_mult,
    input  logic             RDY_mult,
    output logic [OPW-1:0]   mult_input0,
    output logic [OPW-1:0]   mult_input1,
    output logic             EN_blockRead,
    input  logic             VALID_memVal,
    input  logic [WIDTH-1:0] memVal_data,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_last,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int CW = LOGDEPTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(2 ** LOGDEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(2 ** LOGDEPTH - 1);

    seq_state_t       state_q, state_d;
    logic [CW-1:0]    load_cnt_q, load_cnt_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic             res_valid_q, res_valid_d;
    logic             res_last_q, res_last_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             blk_q, blk_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tmr_inc, tmr_clr, tmr_exp;

    assign mult_input0 = op_a;
    assign mult_input1 = op_b;
    assign op_ready    = (state_q == LOAD) && RDY_mult && (load_cnt_q < DEPTH_C);
    assign EN_mult     = op_valid && op_ready;

    // The watchdog only runs while waiting on the multiplier; any beat re-arms it.
    assign tmr_inc = (state_q == WAIT_FULL) || ((state_q == READ) && !VALID_memVal);
    assign tmr_clr = abort || !tmr_inc;

    mult_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_inc),
        .expired (tmr_exp)
    );

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        res_valid_d = 1'b0;
        res_last_d  = 1'b0;
        res_data_d  = res_data_q;
        err_d       = err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d    = LOAD;
                load_cnt_d = '0;
                err_d      = 1'b0;
            end
            LOAD: if (EN_mult) begin
                load_cnt_d = load_cnt_q + CW'(1);
                if (load_cnt_q == LAST_C) state_d = WAIT_FULL;
            end
            WAIT_FULL: begin
                if (tmr_exp) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (!RDY_mult) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d    = READ;
                beat_cnt_d = '0;
            end
            READ: begin
                if (VALID_memVal) begin
                    res_valid_d = 1'b1;
                    res_data_d  = memVal_data;
                    res_last_d  = (beat_cnt_q == LAST_C);
                    beat_cnt_d  = beat_cnt_q + CW'(1);
                    if (beat_cnt_q == LAST_C) state_d = DONE;
                end else if (tmr_exp) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Stray read beats are dropped but remembered as a protocol error.
        if (VALID_memVal && (state_q != READ)) err_d = 1'b1;
        if (abort) begin
            state_d     = IDLE;
            load_cnt_d  = '0;
            beat_cnt_d  = '0;
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
            err_d       = err_q;
        end
        blk_d  = (state_d == ISSUE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            load_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= '0;
            blk_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            res_data_q  <= res_data_d;
            blk_q       <= blk_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign res_valid    = res_valid_q;
    assign res_last     = res_last_q;
    assign res_data     = res_data_q;
    assign EN_blockRead = blk_q;
    assign done         = done_q;
    assign err          = err_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: doc/mult_block_sequencer.md
Name: mult_block_sequencer

Overview:
- Sequences one complete multiply-block transaction on the multiplier datapath.
- Loads 2^LOGDEPTH operand pairs from a host valid/ready stream into the multiplier's EN_mult/RDY_mult handshake.
- Waits for the multiplier to report full, issues a single EN_blockRead, and forwards the read-back product stream to the host.
- Sits between the host/testbench driver and the multiplier. Provides done, abort and timeout-error signalling.

Parameters:
- LOGDEPTH, 6, log2 of block depth; DEPTH = 2**LOGDEPTH products per transaction.
- WIDTH, 32, product/result data width.
- OPW, 16, operand width.
- TIMEOUT, 256, maximum idle cycles tolerated in WAIT_FULL or READ before error.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins a transaction when in IDLE, ignored otherwise.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- op_valid  in  1  host operand pair valid.
- op_ready  out  1  sequencer accepts operand pair.
- op_a  in  OPW  operand A.
- op_b  in  OPW  operand B.
- EN_mult  out  1  to multiplier: operand pair presented this cycle.
- RDY_mult  in  1  from multiplier: ready to accept a pair.
- mult_input0  out  OPW  to multiplier, equals op_a.
- mult_input1  out  OPW  to multiplier, equals op_b.
- EN_blockRead  out  1  to multiplier: one-cycle read-block request.
- VALID_memVal  in  1  from multiplier: read beat valid.
- memVal_data  in  WIDTH  from multiplier: read beat data.
- res_valid  out  1  result beat valid, no backpressure.
- res_data  out  WIDTH  result beat data.
- res_last  out  1  high on final beat (index DEPTH-1).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky timeout/protocol error; cleared by start or rst.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; counters=0; res_valid, res_last, res_data, EN_blockRead, done, err all 0.
- Combinational outputs:
  - mult_input0=op_a and mult_input1=op_b at all times.
  - op_ready = (state==LOAD) & RDY_mult & (load_cnt<DEPTH).
  - EN_mult = op_valid & op_ready. Zero-cycle handshake; a pair transfers when EN_mult=1 at a posedge.
- IDLE:
  - start=1 -> LOAD; load_cnt=0; err cleared.
- LOAD:
  - Each transfer increments load_cnt (LOGDEPTH+1 bits).
  - When the transfer making load_cnt==DEPTH occurs -> WAIT_FULL; wait_cnt=0.
  - op_valid low stalls indefinitely; no timeout in LOAD.
- WAIT_FULL:
  - wait_cnt increments each cycle.
  - When RDY_mult==0 (multiplier full) -> ISSUE.
  - wait_cnt reaching TIMEOUT -> err=1, go IDLE.
- ISSUE:
  - EN_blockRead=1 for exactly this cycle (registered output).
  - -> READ; beat_cnt=0; wait_cnt=0.
- READ:
  - Each VALID_memVal=1 cycle is registered: next cycle res_valid=1, res_data=memVal_data. One-cycle latency.
  - beat_cnt increments per beat.
  - res_last=1 with beat index DEPTH-1.
  - wait_cnt resets on each beat and increments otherwise; reaching TIMEOUT -> err=1, go IDLE.
  - After beat DEPTH-1 -> DONE.
- DONE:
  - done=1 for one cycle -> IDLE.
- Beats beyond DEPTH, or VALID_memVal outside READ: ignored, not forwarded, and set err=1 (sticky). State is unaffected.
- abort=1 in any state: next state IDLE, counters cleared, res_valid=0, no done pulse. err unchanged.
- Priority when signals coincide: rst > abort > timeout > normal transition.
- start while busy: ignored.
- start and abort together in IDLE: abort wins, remain IDLE.
- res_valid has no res_ready; the consumer must accept every beat.

Decomposition:
- Package mult_pkg holds:
  - typedef enum logic [2:0] seq_state_t {IDLE, LOAD, WAIT_FULL, ISSUE, READ, DONE}.
  - Default DEPTH/LOGDEPTH constants.
- Sub-module mult_seq_timer: loadable cycle counter with clear, enable and expired flag (parameter TIMEOUT). Used by WAIT_FULL and READ.
- Everything else stays in mult_block_sequencer.

Test Plan:
- Nominal:
  - Stimulus: start; 64 pairs with op_a=i, op_b=i+1, op_valid held high; behavioural multiplier model.
  - Required: exactly 64 EN_mult pulses; one EN_blockRead pulse after RDY_mult falls; 64 res_valid beats with res_data=i*(i+1); res_last only on beat 63; done pulse; err=0.
- Host stall:
  - Stimulus: op_valid toggles 1/0 every cycle.
  - Required: load takes about 128 cycles; still 64 transfers; same results.
- Multiplier backpressure:
  - Stimulus: RDY_mult low for 5 cycles mid-load.
  - Required: op_ready=0 and EN_mult=0 during the stall; no pair lost.
- Timeout:
  - Stimulus: multiplier model never drops RDY_mult after 64 pairs.
  - Required: err=1 exactly TIMEOUT=256 cycles after entering WAIT_FULL; return to IDLE; no EN_blockRead.
- Abort mid-READ:
  - Stimulus: abort after beat 20.
  - Required: IDLE next cycle; no further res_valid; no done; a new start then runs a clean full transaction.
- Reset mid-LOAD:
  - Stimulus: rst asserted after 10 pairs.
  - Required: all outputs at reset values on the next cycle; busy=0.
